// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered reset release for STAGES domains sharing one clock.
// Every domain reset is held, then released lowest index first. The next domain
// is released only after the current domain's ready bit is seen, followed by a
// guard gap of DELAY cycles.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN. When defined, a domain that
// stays not-ready for TIMEOUT cycles drives the sequencer into a sticky FAULT.
// When undefined, the sequencer waits forever and error stays 0.
// stage_ready is a level qualifier, not a handshake. Bit i is looked at only
// once rst_out[i] has been released. A released domain that later drops ready
// forces a full resequence.
module reset_sequencer #(
  parameter int STAGES  = 4,
  parameter int DELAY   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rst,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  localparam int MAXC = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_GAP      = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] rst_out_q, rst_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [STAGES-1:0] cur_sel;
  logic [STAGES-1:0] below_mask;
  logic [STAGES-1:0] upto_mask;
  logic              cur_ready;
  logic              lost_wait;
  logic              lost_gap;
  logic              lost_any;

  // Decode which domains are released relative to the current index.
  always_comb begin
    cur_sel    = '0;
    below_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      cur_sel[i]    = (IW'(i) == idx_q);
      below_mask[i] = (IW'(i) < idx_q);
    end
  end

  // While waiting, stage idx is not yet expected ready; in the gap it already was.
  assign upto_mask = below_mask | cur_sel;
  assign cur_ready = |(stage_ready & cur_sel);
  assign lost_wait = |(~stage_ready & below_mask);
  assign lost_gap  = |(~stage_ready & upto_mask);
  assign lost_any  = ~&stage_ready;

  // State and output registers; rst clears everything including error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state, counter and index decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (req_rst) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT_RDY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_RDY: begin
          if (lost_wait) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
          end else if (cur_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = '0;
              state_d = ST_GAP;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        ST_GAP: begin
          if (lost_gap) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + IW'(1);
            state_d = ST_WAIT_RDY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (lost_any) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs are a function of the state being entered.
  always_comb begin
    rst_out_d = '1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    error_d   = error_q;
`else
    error_d   = 1'b0;
`endif
    case (state_d)
      ST_WAIT_RDY, ST_GAP: begin
        for (int i = 0; i < STAGES; i++) begin
          rst_out_d[i] = (IW'(i) > idx_d);
        end
      end
      ST_DONE: begin
        rst_out_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end
      ST_FAULT: begin
        busy_d = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
        error_d = 1'b1;
`endif
      end
      default: begin
        rst_out_d = '1;
      end
    endcase
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule
